// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit frame controller.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      STOP2  = 3'd5
   } state_e;

   // Select codes for the downstream 4:1 line multiplexer
   localparam logic [1:0] SEL_START = 2'b00;
   localparam logic [1:0] SEL_STOP  = 2'b01;
   localparam logic [1:0] SEL_DATA  = 2'b10;
   localparam logic [1:0] SEL_PAR   = 2'b11;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational frame parity: XOR-reduce of the payload, inverted for odd parity.
module uart_parity_calc
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  par_typ_i,
   output logic                  par_o
);

   assign par_o = (par_typ_i == PAR_ODD) ? ~(^data_i) : (^data_i);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start, LSB-first data, optional parity, stop.
// Define UART_TX_TWO_STOP_EN to append a second stop bit (STOP2) to every frame.
module uart_tx_ctrl
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  data_valid,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic [1:0]            mux_sel,
   output logic                  ser_data,
   output logic                  par_bit,
   output logic                  busy
);

   localparam int               CNT_W    = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

   // The last stop state is the only mid-frame point where a new payload may be taken
`ifdef UART_TX_TWO_STOP_EN
   localparam state_e LAST_STOP = STOP2;
`else
   localparam state_e LAST_STOP = STOP;
`endif

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  par_en_q, par_en_d;
   logic                  ser_data_q, ser_data_d;
   logic                  par_bit_q, par_bit_d;
   logic                  accept;
   logic                  par_calc;

   uart_parity_calc #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_parity (
      .data_i    (p_data),
      .par_typ_i (par_typ),
      .par_o     (par_calc)
   );

   always_comb begin
      accept = 1'b0;
      if ((state_q == IDLE) || (state_q == LAST_STOP)) begin
         accept = data_valid;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = START;
         START:   state_d = DATA;
         DATA:    if (cnt_q == CNT_LAST) state_d = par_en_q ? PARITY : STOP;
         PARITY:  state_d = STOP;
`ifdef UART_TX_TWO_STOP_EN
         STOP:    state_d = STOP2;
`else
         STOP:    state_d = accept ? START : IDLE;
`endif
         STOP2:   state_d = accept ? START : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mux_sel = SEL_STOP;
      busy    = 1'b1;
      case (state_q)
         IDLE:    busy    = 1'b0;
         START:   mux_sel = SEL_START;
         DATA:    mux_sel = SEL_DATA;
         PARITY:  mux_sel = SEL_PAR;
         default: mux_sel = SEL_STOP;
      endcase
   end

   // ser_data is loaded one edge ahead so it already holds bit n during the n-th DATA cycle
   always_comb begin
      shift_d    = shift_q;
      cnt_d      = cnt_q;
      par_en_d   = par_en_q;
      par_bit_d  = par_bit_q;
      ser_data_d = 1'b0;
      if (accept) begin
         shift_d   = p_data;
         par_en_d  = par_en;
         par_bit_d = par_calc;
         cnt_d     = '0;
      end else if ((state_q == START) || (state_q == DATA)) begin
         shift_d = shift_q >> 1;
         if (state_d == DATA) begin
            ser_data_d = shift_q[0];
         end
         if (state_q == START) begin
            cnt_d = '0;
         end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q    <= '0;
         cnt_q      <= '0;
         par_en_q   <= 1'b0;
         ser_data_q <= 1'b0;
         par_bit_q  <= 1'b0;
      end else begin
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         par_en_q   <= par_en_d;
         ser_data_q <= ser_data_d;
         par_bit_q  <= par_bit_d;
      end
   end

   assign ser_data = ser_data_q;
   assign par_bit  = par_bit_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: each accepted frame queues its per-cycle line expectations.
module tb_uart_tx_ctrl;
   import uart_tx_pkg::*;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [DW-1:0] p_data = '0;
   logic          data_valid = 1'b0;
   logic          par_en = 1'b0;
   logic          par_typ = 1'b0;
   logic [1:0]    mux_sel;
   logic          ser_data;
   logic          par_bit;
   logic          busy;

   typedef struct {
      logic [1:0] sel;
      logic       chk_ser;
      logic       ser;
      logic       par;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;
   bit   mon_en = 1'b0;

   uart_tx_ctrl #(
      .DATA_WIDTH (DW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .p_data     (p_data),
      .data_valid (data_valid),
      .par_en     (par_en),
      .par_typ    (par_typ),
      .mux_sel    (mux_sel),
      .ser_data   (ser_data),
      .par_bit    (par_bit),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic push_frame(input logic [DW-1:0] d, input logic pe, input logic pt);
      exp_t e;
      logic p;
      p = pt ^ (^d);
      e.sel = 2'b00; e.chk_ser = 1'b0; e.ser = 1'b0; e.par = p;
      exp_q.push_back(e);
      for (int i = 0; i < DW; i++) begin
         e.sel = 2'b10; e.chk_ser = 1'b1; e.ser = d[i];
         exp_q.push_back(e);
      end
      e.chk_ser = 1'b0;
      if (pe) begin
         e.sel = 2'b11;
         exp_q.push_back(e);
      end
      e.sel = 2'b01;
      exp_q.push_back(e);
`ifdef UART_TX_TWO_STOP_EN
      exp_q.push_back(e);
`endif
   endtask

   // One expected entry per busy cycle; an empty queue means the line must be idle
   always @(negedge clk) begin
      if (mon_en) begin
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check_val("sel", 32'(mux_sel), 32'(mon_e.sel));
            check_val("busy", 32'(busy), 32'd1);
            if (mon_e.chk_ser) check_val("ser_data", 32'(ser_data), 32'(mon_e.ser));
            check_val("par_bit", 32'(par_bit), 32'(mon_e.par));
         end else begin
            check_val("idle_sel", 32'(mux_sel), 32'd1);
            check_val("idle_busy", 32'(busy), 32'd0);
            check_val("idle_ser", 32'(ser_data), 32'd0);
         end
      end
   end

   task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt);
      @(negedge clk); #1;
      p_data = d; par_en = pe; par_typ = pt; data_valid = 1'b1;
      push_frame(d, pe, pt);
      $display("send data=%02h par_en=%0d par_typ=%0d t=%0t", d, pe, pt, $time);
      @(negedge clk); #1;
      data_valid = 1'b0;
      // Scramble the inputs mid-frame; the frame in flight must not change
      p_data = ~d; par_en = ~pe; par_typ = ~pt;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check_val("drain_timeout", 32'(exp_q.size()), 32'd0);
      @(negedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      #1 rst_n = 1'b0;
      #2;
      check_val("rst_sel", 32'(mux_sel), 32'd1);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_ser", 32'(ser_data), 32'd0);
      check_val("rst_par", 32'(par_bit), 32'd0);
      mon_en = 1'b1;
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (5) @(negedge clk);
      #1;

      send(8'hA5, 1'b1, 1'b0);
      wait_drain();
      send(8'hA5, 1'b1, 1'b1);
      wait_drain();
      send(8'hA5, 1'b0, 1'b0);
      wait_drain();

      // Held valid: second payload must start straight after the last stop cycle
      @(negedge clk); #1;
      p_data = 8'h3C; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
      push_frame(8'h3C, 1'b0, 1'b0);
      $display("send held data=3c then c3 t=%0t", $time);
      @(negedge clk); #1;
      p_data = 8'hC3;
      push_frame(8'hC3, 1'b0, 1'b0);
      repeat (11) @(negedge clk);
      #1 data_valid = 1'b0;
      wait_drain();

      // Valid pulses during DATA must be ignored
      send(8'h96, 1'b1, 1'b1);
      repeat (3) @(negedge clk);
      #1 p_data = 8'hFF; data_valid = 1'b1;
      @(negedge clk); #1 data_valid = 1'b0;
      repeat (2) @(negedge clk);
      #1 p_data = 8'h00; data_valid = 1'b1;
      @(negedge clk); #1 data_valid = 1'b0;
      wait_drain();

      // Reset during the 4th data bit aborts the frame at once
      send(8'hE7, 1'b1, 1'b0);
      repeat (4) @(negedge clk);
      #1 rst_n = 1'b0;
      exp_q.delete();
      $display("reset mid-frame t=%0t", $time);
      #1;
      check_val("abort_sel", 32'(mux_sel), 32'd1);
      check_val("abort_busy", 32'(busy), 32'd0);
      check_val("abort_ser", 32'(ser_data), 32'd0);
      check_val("abort_par", 32'(par_bit), 32'd0);
      @(negedge clk); #1 rst_n = 1'b1;
      @(negedge clk); #1;
      send(8'h5A, 1'b1, 1'b0);
      wait_drain();

`ifdef UART_TX_TWO_STOP_EN
      // Valid in the first stop is ignored, valid in the second stop is taken
      send(8'hFF, 1'b0, 1'b0);
      repeat (9) @(negedge clk);
      #1 p_data = 8'h11; par_en = 1'b1; par_typ = 1'b0; data_valid = 1'b1;
      @(negedge clk); #1;
      push_frame(8'h11, 1'b1, 1'b0);
      $display("send in stop2 data=11 t=%0t", $time);
      @(negedge clk); #1 data_valid = 1'b0;
      wait_drain();
`endif

      repeat (3) @(negedge clk);
      mon_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
